// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the dual-port SRAM arbiter.
package sram_arb_pkg;

    localparam int unsigned NUM_PORTS = 2;
    localparam int unsigned RSP_DEPTH = 2;

    // Macro geometry; the arbiter's BITS/ADDR_WIDTH must match these.
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 14;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] wmask;
    } req_t;

    // Read issued last cycle whose data is on the macro output now.
    typedef struct packed {
        logic valid;
        logic port;
    } inflight_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Two-entry synchronous response FIFO; head is presented combinationally.
module sram_rsp_fifo #(
    parameter int unsigned BITS = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic [BITS-1:0] wdata_i,
    input  logic            pop_i,
    output logic [BITS-1:0] rdata_o,
    output logic            full_o,
    output logic            empty_o
);

    logic [BITS-1:0] mem_q [2];
    logic            wr_ptr_q;
    logic            rd_ptr_q;
    logic [1:0]      count_q;
    logic [1:0]      count_d;

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= ~wr_ptr_q;
            if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end

    // Data storage, no reset needed.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/sram_1rw_arbiter.sv
// Round-robin arbiter sharing one 1RW SRAM macro between two requesters,
// with credit-gated per-port read response FIFOs.
module sram_1rw_arbiter #(
    parameter int unsigned BITS       = 32,
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned RSP_DEPTH  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [1:0]              req_valid_i,
    output logic [1:0]              req_ready_o,
    input  logic [1:0]              req_we_i,
    input  logic [2*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [2*BITS-1:0]       req_wdata_i,
    input  logic [2*BITS-1:0]       req_wmask_i,
    output logic [1:0]              rsp_valid_o,
    input  logic [1:0]              rsp_ready_i,
    output logic [2*BITS-1:0]       rsp_rdata_o,
    output logic                    sram_ce_o,
    output logic                    sram_we_o,
    output logic [ADDR_WIDTH-1:0]   sram_addr_o,
    output logic [BITS-1:0]         sram_wd_o,
    output logic [BITS-1:0]         sram_wmask_o,
    input  logic [BITS-1:0]         sram_rd_i
);

    import sram_arb_pkg::*;

    req_t                 req [NUM_PORTS];
    req_t                 gnt_req;
    logic [NUM_PORTS-1:0] elig;
    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] pop;
    logic [NUM_PORTS-1:0] fifo_full;
    logic [NUM_PORTS-1:0] fifo_empty;
    logic                 gnt_valid;
    logic                 gnt_port;
    logic                 rr_q;
    logic                 rr_d;
    inflight_t            infl_q;
    inflight_t            infl_d;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        localparam logic PID = 1'(p);

        logic [1:0] credit_q;
        logic [1:0] credit_d;
        logic       rd_grant;

        assign req[p] = '{
            we:    req_we_i[p],
            addr:  req_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH],
            wdata: req_wdata_i[p*BITS +: BITS],
            wmask: req_wmask_i[p*BITS +: BITS]
        };

        // Reads need a free response slot; writes never consume one.
        assign elig[p]        = req_valid_i[p] && (req_we_i[p] || credit_q < 2'(RSP_DEPTH));
        assign rd_grant       = gnt_valid && (gnt_port == PID) && !req_we_i[p];
        assign push[p]        = infl_q.valid && (infl_q.port == PID);
        assign rsp_valid_o[p] = !fifo_empty[p] && !rst_i;
        assign pop[p]         = rsp_valid_o[p] && rsp_ready_i[p];

        // Credit tracks reads granted but not yet popped.
        always_comb begin
            credit_d = credit_q;
            case ({rd_grant, pop[p]})
                2'b10:   credit_d = credit_q + 2'd1;
                2'b01:   credit_d = credit_q - 2'd1;
                default: credit_d = credit_q;
            endcase
        end

        // Credit register.
        always_ff @(posedge clk_i) begin
            if (rst_i) credit_q <= '0;
            else       credit_q <= credit_d;
        end

        sram_rsp_fifo #(
            .BITS (BITS)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (push[p]),
            .wdata_i (sram_rd_i),
            .pop_i   (pop[p]),
            .rdata_o (rsp_rdata_o[p*BITS +: BITS]),
            .full_o  (fifo_full[p]),
            .empty_o (fifo_empty[p])
        );

        a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
            !(push[p] && fifo_full[p]));
    end

    // Round-robin pick among eligible ports; nothing is granted during reset.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_port  = 1'b0;
        if (!rst_i) begin
            gnt_valid = |elig;
            gnt_port  = (&elig) ? rr_q : elig[1];
        end
    end

    assign gnt_req     = gnt_port ? req[1] : req[0];
    assign req_ready_o = {gnt_valid & gnt_port, gnt_valid & ~gnt_port};

    // Macro drive: granted request fields, all-zero when idle.
    always_comb begin
        sram_ce_o    = gnt_valid;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wd_o    = '0;
        sram_wmask_o = '0;
        if (gnt_valid) begin
            sram_we_o    = gnt_req.we;
            sram_addr_o  = gnt_req.addr;
            sram_wd_o    = gnt_req.wdata;
            sram_wmask_o = gnt_req.wmask;
        end
    end

    // Next pointer and in-flight tag.
    always_comb begin
        rr_d         = gnt_valid ? ~gnt_port : rr_q;
        infl_d.valid = gnt_valid && !gnt_req.we;
        infl_d.port  = gnt_port;
    end

    // Arbitration state; reset drops any in-flight read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q   <= 1'b0;
            infl_q <= '0;
        end else begin
            rr_q   <= rr_d;
            infl_q <= infl_d;
        end
    end

endmodule
